// File: rtl/im_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package im_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [7:0] LOADER_HEADER = 8'hA5;
  localparam int CNT_W = 16;
  localparam int WORD_W = 32;

endpackage

// File: rtl/word_assembler.sv
// Collects four big-endian bytes into one instruction word.
module word_assembler
  import im_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-9:0] shift_q, shift_d;
  logic [1:0]        idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clr) begin
      shift_d = '0;
      idx_d   = 2'd0;
    end else if (in_valid) begin
      shift_d = {shift_q[WORD_W-17:0], in_byte};
      idx_d   = idx_q + 2'd1;
    end
  end

  // The 4th byte completes the word in the same cycle it arrives.
  assign word_valid = in_valid && !clr && (idx_q == 2'd3);
  assign word       = {shift_q, in_byte};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      idx_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Frame parser that programs IM and holds the CPU in reset until
// a frame with a good checksum has been written.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int bit_size = 32,
  parameter int mem_size = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic                IM_wr_en,
  output logic [mem_size-1:0] IM_wr_Address,
  output logic [bit_size-1:0] IM_wr_Data,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  state_e state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [mem_size-1:0] addr_q, addr_d;
  logic [7:0]          chk_q, chk_d;
  logic                wr_en_q, wr_en_d;
  logic [mem_size-1:0] wr_addr_q, wr_addr_d;
  logic [bit_size-1:0] wr_data_q, wr_data_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ready_q;

  logic              accept;
  logic              is_hdr;
  logic              asm_clr;
  logic              asm_in;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic [CNT_W-1:0]  cnt_full;

  assign accept   = byte_valid && ready_q;
  assign is_hdr   = (byte_data == LOADER_HEADER);
  assign cnt_full = {cnt_q[CNT_W-1:8], byte_data};

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .in_valid   (asm_in),
    .in_byte    (byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    chk_d     = chk_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;
    asm_clr   = 1'b0;
    asm_in    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept && is_hdr) state_d = S_CNT_HI;
      end
      S_CNT_HI: begin
        if (accept) begin
          cnt_d   = {byte_data, 8'h00};
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          cnt_d   = cnt_full;
          addr_d  = '0;
          chk_d   = 8'h00;
          asm_clr = 1'b1;
          state_d = (cnt_full == '0) ? S_CHK : S_DATA;
        end
      end
      S_DATA: begin
        asm_in = accept;
        if (accept) begin
          chk_d = chk_q ^ byte_data;
          if (word_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = bit_size'(word);
            addr_d    = addr_q + mem_size'(1);
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          if (byte_data == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b0;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            done_d  = 1'b0;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (accept && is_hdr) begin
          state_d = S_CNT_HI;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      chk_q     <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      chk_q     <= chk_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= 1'b1;
    end
  end

  assign byte_ready    = ready_q;
  assign IM_wr_en      = wr_en_q;
  assign IM_wr_Address = wr_addr_q;
  assign IM_wr_Data    = wr_data_q;
  assign cpu_hold      = hold_q;
  assign done          = done_q;
  assign error         = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Randomised frame bench for im_loader with a frame-level reference:
// expected writes are the frame words at 0..N-1, flags follow the checksum.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        IM_wr_en;
  logic [15:0] IM_wr_Address;
  logic [31:0] IM_wr_Data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  im_loader #(.bit_size(32), .mem_size(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .IM_wr_en      (IM_wr_en),
    .IM_wr_Address (IM_wr_Address),
    .IM_wr_Data    (IM_wr_Data),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [47:0] wlog[$];
  logic [31:0] fw[$];
  int cyc = 0;
  int last_wr = -1;
  int min_gap = 1000;
  int back2back = 0;
  logic prev_en = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      prev_en = 1'b0;
      last_wr = -1;
    end else begin
      if (IM_wr_en) begin
        wlog.push_back({IM_wr_Address, IM_wr_Data});
        if (prev_en) back2back++;
        if (last_wr >= 0 && cyc - last_wr < min_gap) min_gap = cyc - last_wr;
        last_wr = cyc;
      end
      prev_en = IM_wr_en;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    int t;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    t = 0;
    while (!byte_ready && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!byte_ready) check("ready_timeout", 64'(byte_ready), 64'd1);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  // Everything after the header: count, data words MSB first, checksum.
  task automatic send_body(input logic corrupt, input int maxgap);
    logic [7:0] chk;
    logic [15:0] n;
    chk = 8'h00;
    n = 16'(fw.size());
    send_byte(n[15:8], maxgap);
    send_byte(n[7:0], maxgap);
    foreach (fw[i]) begin
      for (int k = 3; k >= 0; k--) begin
        chk = chk ^ fw[i][8*k +: 8];
        send_byte(fw[i][8*k +: 8], maxgap);
      end
    end
    send_byte(corrupt ? (chk ^ 8'h01) : chk, maxgap);
  endtask

  task automatic verify(input string tag, input logic corrupt);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_nwr"}, 64'(wlog.size()), 64'(fw.size()));
    foreach (fw[i]) begin
      if (i < wlog.size()) begin
        check({tag, "_addr"}, 64'(wlog[i][47:32]), 64'(i));
        check({tag, "_data"}, 64'(wlog[i][31:0]), 64'(fw[i]));
      end
    end
    check({tag, "_done"}, 64'(done), 64'(!corrupt));
    check({tag, "_error"}, 64'(error), 64'(corrupt));
    check({tag, "_hold"}, 64'(cpu_hold), 64'(corrupt));
  endtask

  task automatic load_first();
    fw.delete();
    fw.push_back(32'hDEADBEEF);
    fw.push_back(32'h0000002A);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_wren"}, 64'(IM_wr_en), 64'd0);
    check({tag, "_addr"}, 64'(IM_wr_Address), 64'd0);
    check({tag, "_data"}, 64'(IM_wr_Data), 64'd0);
    check({tag, "_hold"}, 64'(cpu_hold), 64'd1);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    #12;
    check_reset_outs("rst0");
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("ready_pre_edge", 64'(byte_ready), 64'd0);
    @(posedge clk);
    #1;
    check("ready_post_edge", 64'(byte_ready), 64'd1);

    // garbage then empty frame
    wlog.delete();
    fw.delete();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'hA5, 0);
    send_body(1'b0, 0);
    verify("empty", 1'b0);

    wlog.delete();
    load_first();
    send_byte(8'hA5, 0);
    send_body(1'b0, 0);
    verify("b2b", 1'b0);

    wlog.delete();
    send_byte(8'hA5, 0);
    send_body(1'b1, 0);
    verify("badchk", 1'b1);

    wlog.delete();
    send_byte(8'hA5, 5);
    send_body(1'b0, 5);
    verify("gaps", 1'b0);

    // reset after the 6th byte of the first frame
    wlog.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_nowr", 64'(wlog.size()), 64'd0);
    send_byte(8'hA5, 0);
    send_body(1'b0, 0);
    verify("after_rst", 1'b0);

    // restart from DONE
    wlog.delete();
    fw.delete();
    fw.push_back(32'h12345678);
    send_byte(8'hA5, 0);
    check("restart_done", 64'(done), 64'd0);
    check("restart_hold", 64'(cpu_hold), 64'd1);
    send_body(1'b0, 0);
    verify("restart", 1'b0);

    for (int it = 0; it < 6; it++) begin
      logic c;
      logic [7:0] g;
      wlog.delete();
      fw.delete();
      repeat ($urandom_range(6, 1)) fw.push_back($urandom);
      c = 1'($urandom_range(1, 0));
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h00;
      send_byte(g, 2);
      send_byte(8'hA5, 3);
      send_body(c, 3);
      verify("rand", c);
    end

    check("strobe_1cyc", 64'(back2back), 64'd0);
    check("wr_spacing", 64'(min_gap >= 4), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
